// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: bundles the instruction queue's enqueue, dequeue and flush signals
// Ports: master drives flush, the enqueue group and deq_num; slave (the queue) drives
//        in_ready, the two output slots and count.
interface inst_fetch_queue_if #(parameter int DEPTH = 16, parameter int CP_W = 16, parameter int EXC_W = 5);
    localparam int CW = $clog2(DEPTH) + 1;
    logic               flush_i;
    logic               in_valid_i;
    logic [2:0]         in_num_i;
    logic [127:0]       in_inst_p_i;
    logic [127:0]       in_predDest_p_i;
    logic [3:0]         in_predTake_p_i;
    logic [4*CP_W-1:0]  in_predInfo_p_i;
    logic [31:0]        in_basePC_i;
    logic               in_hasException_i;
    logic               in_isRefill_i;
    logic [EXC_W-1:0]   in_excCode_i;
    logic               in_ready_o;
    logic [1:0]         out_valid_o;
    logic [63:0]        out_inst_p_o;
    logic [63:0]        out_pc_p_o;
    logic [63:0]        out_predDest_p_o;
    logic [1:0]         out_predTake_p_o;
    logic [2*CP_W-1:0]  out_predInfo_p_o;
    logic [1:0]         out_hasException_o;
    logic [1:0]         out_isRefill_o;
    logic [2*EXC_W-1:0] out_excCode_p_o;
    logic [1:0]         deq_num_i;
    logic [CW-1:0]      count_o;
    modport master (
        output flush_i, in_valid_i, in_num_i, in_inst_p_i, in_predDest_p_i, in_predTake_p_i,
               in_predInfo_p_i, in_basePC_i, in_hasException_i, in_isRefill_i, in_excCode_i, deq_num_i,
        input  in_ready_o, out_valid_o, out_inst_p_o, out_pc_p_o, out_predDest_p_o, out_predTake_p_o,
               out_predInfo_p_o, out_hasException_o, out_isRefill_o, out_excCode_p_o, count_o
    );
    modport slave (
        input  flush_i, in_valid_i, in_num_i, in_inst_p_i, in_predDest_p_i, in_predTake_p_i,
               in_predInfo_p_i, in_basePC_i, in_hasException_i, in_isRefill_i, in_excCode_i, deq_num_i,
        output in_ready_o, out_valid_o, out_inst_p_o, out_pc_p_o, out_predDest_p_o, out_predTake_p_o,
               out_predInfo_p_o, out_hasException_o, out_isRefill_o, out_excCode_p_o, count_o
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: circular instruction queue between IF tail and decode, 4-wide in, 2-wide out
// Ports: clk, rst (sync, active-low); bus (slave) carries the enqueue group, flush,
//        deq_num and the two oldest-entry output slots plus occupancy.
module inst_fetch_queue #(
    parameter int DEPTH = 16,
    parameter int CP_W  = 16,
    parameter int EXC_W = 5
) (
    input logic              clk,
    input logic              rst,
    inst_fetch_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [31:0]      inst_q [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      dest_q [DEPTH];
    logic             take_q [DEPTH];
    logic [CP_W-1:0]  info_q [DEPTH];
    logic             exc_q  [DEPTH];
    logic             refill_q [DEPTH];
    logic [EXC_W-1:0] code_q [DEPTH];
    logic [2:0]       enq_num;
    logic [1:0]       deq_lim;
    logic [CW-1:0]    eff_deq;
    logic             ready;
    logic             enq;
    logic [AW-1:0]    widx [4];
    logic             wen  [4];
    logic [AW-1:0]    ridx [2];
    always_comb begin
        ready   = count_q <= CW'(DEPTH - 4);
        // Illegal counts above 4 are clamped so at most the four physical lanes are written.
        enq_num = bus.in_num_i > 3'd4 ? 3'd4 : bus.in_num_i;
        enq     = bus.in_valid_i && ready && !bus.flush_i && enq_num != 3'd0;
        deq_lim = bus.deq_num_i == 2'd3 ? 2'd2 : bus.deq_num_i;
        eff_deq = CW'(deq_lim) > count_q ? count_q : CW'(deq_lim);
        head_d  = bus.flush_i ? '0 : head_q + AW'(eff_deq);
        tail_d  = bus.flush_i ? '0 : tail_q + (enq ? AW'(enq_num) : '0);
        count_d = bus.flush_i ? '0 : count_q + (enq ? CW'(enq_num) : '0) - eff_deq;
        for (int k = 0; k < 4; k++) begin
            widx[k] = tail_q + AW'(k);
            wen[k]  = enq && 3'(k) < enq_num;
        end
        for (int j = 0; j < 2; j++) ridx[j] = head_q + AW'(j);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
    // Entry storage has no reset; validity is tracked only by count.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst && wen[k]) begin
                inst_q[widx[k]]   <= bus.in_inst_p_i[32*k +: 32];
                pc_q[widx[k]]     <= bus.in_basePC_i + 32'(4 * k);
                dest_q[widx[k]]   <= bus.in_predDest_p_i[32*k +: 32];
                take_q[widx[k]]   <= bus.in_predTake_p_i[k];
                info_q[widx[k]]   <= bus.in_predInfo_p_i[CP_W*k +: CP_W];
                exc_q[widx[k]]    <= bus.in_hasException_i;
                refill_q[widx[k]] <= bus.in_isRefill_i;
                code_q[widx[k]]   <= bus.in_excCode_i;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst && bus.in_valid_i) assert (bus.in_num_i <= 3'd4);
    end
    always_comb begin
        bus.in_ready_o = ready;
        bus.count_o    = count_q;
        for (int j = 0; j < 2; j++) begin
            bus.out_valid_o[j]                    = count_q > CW'(j);
            bus.out_inst_p_o[32*j +: 32]          = inst_q[ridx[j]];
            bus.out_pc_p_o[32*j +: 32]            = pc_q[ridx[j]];
            bus.out_predDest_p_o[32*j +: 32]      = dest_q[ridx[j]];
            bus.out_predTake_p_o[j]               = take_q[ridx[j]];
            bus.out_predInfo_p_o[CP_W*j +: CP_W]  = info_q[ridx[j]];
            bus.out_hasException_o[j]             = exc_q[ridx[j]];
            bus.out_isRefill_o[j]                 = refill_q[ridx[j]];
            bus.out_excCode_p_o[EXC_W*j +: EXC_W] = code_q[ridx[j]];
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed table-driven bench for inst_fetch_queue (DEPTH=16)
module tb_inst_fetch_queue;
    logic clk;
    logic rst;
    int   tests;
    int   fails;
    inst_fetch_queue_if #(.DEPTH(16), .CP_W(16), .EXC_W(5)) bus ();
    inst_fetch_queue #(.DEPTH(16), .CP_W(16), .EXC_W(5)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    typedef struct {
        logic        vld;
        logic        fl;
        logic [2:0]  n;
        logic [31:0] base;
        logic [31:0] seed;
        logic [1:0]  dq;
        logic [1:0]  ev;
        logic [4:0]  ecnt;
        logic        erdy;
        logic [31:0] i0;
        logic [31:0] p0;
        logic [31:0] i1;
        logic [31:0] p1;
    } vec_t;
    vec_t v[$];
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    // Lane k carries inst seed+k, target seed+k+0x1000_0000, taken k odd, checkpoint low 16 bits of inst.
    task automatic step(input logic r, input logic vld, input logic fl, input logic [2:0] n,
                        input logic [31:0] base, input logic [31:0] seed, input logic [1:0] dq,
                        input logic ex, input logic rf, input logic [4:0] ec);
        @(negedge clk);
        rst = r;
        bus.flush_i = fl;
        bus.in_valid_i = vld;
        bus.in_num_i = n;
        bus.in_basePC_i = base;
        bus.in_hasException_i = ex;
        bus.in_isRefill_i = rf;
        bus.in_excCode_i = ec;
        bus.deq_num_i = dq;
        for (int k = 0; k < 4; k++) begin
            bus.in_inst_p_i[32*k +: 32] = seed + 32'(k);
            bus.in_predDest_p_i[32*k +: 32] = seed + 32'(k) + 32'h1000_0000;
            bus.in_predTake_p_i[k] = (k % 2) == 1;
            bus.in_predInfo_p_i[16*k +: 16] = 16'(seed + 32'(k));
        end
        @(posedge clk);
        #1;
    endtask
    initial begin
        tests = 0;
        fails = 0;
        v.push_back('{1, 0, 4, 32'h1FC0_0000, 32'hA0, 0, 2'b11, 4, 1, 32'hA0, 32'h1FC0_0000, 32'hA1, 32'h1FC0_0004});
        v.push_back('{0, 0, 0, 0, 0, 2, 2'b11, 2, 1, 32'hA2, 32'h1FC0_0008, 32'hA3, 32'h1FC0_000C});
        v.push_back('{0, 0, 0, 0, 0, 2, 2'b00, 0, 1, 0, 0, 0, 0});
        v.push_back('{1, 0, 4, 32'h100, 32'hB0, 0, 2'b11, 4, 1, 32'hB0, 32'h100, 32'hB1, 32'h104});
        v.push_back('{1, 0, 4, 32'h200, 32'hC0, 0, 2'b11, 8, 1, 32'hB0, 32'h100, 32'hB1, 32'h104});
        v.push_back('{1, 0, 4, 32'h300, 32'hD0, 0, 2'b11, 12, 1, 32'hB0, 32'h100, 32'hB1, 32'h104});
        v.push_back('{1, 0, 4, 32'h400, 32'hE0, 0, 2'b11, 16, 0, 32'hB0, 32'h100, 32'hB1, 32'h104});
        v.push_back('{1, 0, 4, 32'h500, 32'hF0, 0, 2'b11, 16, 0, 32'hB0, 32'h100, 32'hB1, 32'h104});
        v.push_back('{1, 0, 4, 32'h500, 32'hF0, 2, 2'b11, 14, 0, 32'hB2, 32'h108, 32'hB3, 32'h10C});
        v.push_back('{0, 0, 0, 0, 0, 2, 2'b11, 12, 1, 32'hC0, 32'h200, 32'hC1, 32'h204});
        v.push_back('{1, 0, 4, 32'h600, 32'h60, 2, 2'b11, 14, 0, 32'hC2, 32'h208, 32'hC3, 32'h20C});
        v.push_back('{0, 0, 0, 0, 0, 3, 2'b11, 12, 1, 32'hD0, 32'h300, 32'hD1, 32'h304});
        v.push_back('{1, 1, 3, 32'h700, 32'h70, 2, 2'b00, 0, 1, 0, 0, 0, 0});
        v.push_back('{1, 0, 1, 32'h700, 32'h70, 0, 2'b01, 1, 1, 32'h70, 32'h700, 0, 0});
        v.push_back('{0, 0, 0, 0, 0, 2, 2'b00, 0, 1, 0, 0, 0, 0});
        v.push_back('{1, 0, 4, 32'h800, 32'h80, 0, 2'b11, 4, 1, 32'h80, 32'h800, 32'h81, 32'h804});
        v.push_back('{1, 0, 4, 32'h900, 32'h90, 2, 2'b11, 6, 1, 32'h82, 32'h808, 32'h83, 32'h80C});
        v.push_back('{1, 0, 4, 32'hA00, 32'hA0, 2, 2'b11, 8, 1, 32'h90, 32'h900, 32'h91, 32'h904});
        v.push_back('{1, 0, 1, 32'hB00, 32'hB0, 2, 2'b11, 7, 1, 32'h92, 32'h908, 32'h93, 32'h90C});
        v.push_back('{0, 0, 0, 0, 0, 2, 2'b11, 5, 1, 32'hA0, 32'hA00, 32'hA1, 32'hA04});
        v.push_back('{0, 0, 0, 0, 0, 2, 2'b11, 3, 1, 32'hA2, 32'hA08, 32'hA3, 32'hA0C});
        v.push_back('{0, 0, 0, 0, 0, 2, 2'b01, 1, 1, 32'hB0, 32'hB00, 0, 0});
        v.push_back('{0, 0, 0, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0, 0});
        v.push_back('{1, 0, 3, 32'h8000_0010, 32'hC0, 0, 2'b11, 3, 1, 32'hC0, 32'h8000_0010, 32'hC1, 32'h8000_0014});
        v.push_back('{0, 0, 0, 0, 0, 1, 2'b11, 2, 1, 32'hC1, 32'h8000_0014, 32'hC2, 32'h8000_0018});
        v.push_back('{0, 0, 0, 0, 0, 1, 2'b01, 1, 1, 32'hC2, 32'h8000_0018, 0, 0});
        v.push_back('{0, 0, 0, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0, 0});
        rst = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_valid", 64'(bus.out_valid_o), 64'h0);
        chk("reset_count", 64'(bus.count_o), 64'h0);
        chk("reset_ready", 64'(bus.in_ready_o), 64'h1);
        for (int i = 0; i < v.size(); i++) begin
            step(1, v[i].vld, v[i].fl, v[i].n, v[i].base, v[i].seed, v[i].dq, 0, 0, 0);
            chk($sformatf("v%0d_valid", i), 64'(bus.out_valid_o), 64'(v[i].ev));
            chk($sformatf("v%0d_count", i), 64'(bus.count_o), 64'(v[i].ecnt));
            chk($sformatf("v%0d_ready", i), 64'(bus.in_ready_o), 64'(v[i].erdy));
            if (v[i].ev[0]) begin
                chk($sformatf("v%0d_inst0", i), 64'(bus.out_inst_p_o[31:0]), 64'(v[i].i0));
                chk($sformatf("v%0d_pc0", i), 64'(bus.out_pc_p_o[31:0]), 64'(v[i].p0));
            end
            if (v[i].ev[1]) begin
                chk($sformatf("v%0d_inst1", i), 64'(bus.out_inst_p_o[63:32]), 64'(v[i].i1));
                chk($sformatf("v%0d_pc1", i), 64'(bus.out_pc_p_o[63:32]), 64'(v[i].p1));
            end
        end
        step(1, 1, 0, 2, 32'h1000, 32'hE0, 0, 1, 1, 5'h04);
        chk("exc_count", 64'(bus.count_o), 64'd2);
        chk("exc_flag", 64'(bus.out_hasException_o), 64'h3);
        chk("exc_refill", 64'(bus.out_isRefill_o), 64'h3);
        chk("exc_code", 64'(bus.out_excCode_p_o), 64'h084);
        chk("exc_dest", 64'(bus.out_predDest_p_o), 64'h1000_00E1_1000_00E0);
        chk("exc_take", 64'(bus.out_predTake_p_o), 64'h2);
        chk("exc_info", 64'(bus.out_predInfo_p_o), 64'h00E1_00E0);
        chk("exc_pc", 64'(bus.out_pc_p_o), 64'h0000_1004_0000_1000);
        step(0, 1, 1, 4, 32'h2000, 32'h10, 2, 0, 0, 0);
        chk("midrst_valid", 64'(bus.out_valid_o), 64'h0);
        chk("midrst_count", 64'(bus.count_o), 64'h0);
        chk("midrst_ready", 64'(bus.in_ready_o), 64'h1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_count", 64'(bus.count_o), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction queue between the branch select/check stage (IF tail) and decode.
- Accepts up to 4 compressed instructions per cycle, each with its branch prediction info and exception info, and reconstructs each instruction's PC.
- Presents up to 2 oldest instructions per cycle to decode, which dequeues 0–2 of them.
- Supports a single-cycle flush on pipeline redirect.

Parameters:
- DEPTH, 16, entry count; power of 2, minimum 8.
- CP_W, 16, width of the combined checkpoint for one instruction (GHT+RAS).
- EXC_W, 5, exception code width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- flush_i  in  1  discard all contents
- in_valid_i  in  1  group write request
- in_num_i  in  3  instructions in group, 0..4; lanes 0..in_num-1 valid
- in_inst_p_i  in  128  instructions, lane k at [32k+31:32k]
- in_predDest_p_i  in  128  per-lane predicted target
- in_predTake_p_i  in  4  per-lane predicted taken
- in_predInfo_p_i  in  4*CP_W  per-lane checkpoint
- in_basePC_i  in  32  PC of lane 0
- in_hasException_i  in  1  group exception flag
- in_isRefill_i  in  1  TLB refill flag
- in_excCode_i  in  EXC_W  group exception code
- in_ready_o  out  1  queue can take a full group
- out_valid_o  out  2  bit j: slot j holds a valid entry
- out_inst_p_o  out  64  slot j instruction
- out_pc_p_o  out  64  slot j PC
- out_predDest_p_o  out  64  slot j predicted target
- out_predTake_p_o  out  2  slot j predicted taken
- out_predInfo_p_o  out  2*CP_W  slot j checkpoint
- out_hasException_o  out  2  slot j exception flag
- out_isRefill_o  out  2  slot j refill flag
- out_excCode_p_o  out  2*EXC_W  slot j exception code
- deq_num_i  in  2  entries decode consumes this cycle, 0..2
- count_o  out  log2(DEPTH)+1  occupancy

Behaviour:
- Storage: circular buffer with head (read) and tail (write) pointers of log2(DEPTH) bits, wrapping modulo DEPTH, plus a count register.
- Reset (rst==0 at posedge): head=0, tail=0, count=0. As a result, out_valid_o=0, count_o=0 and in_ready_o=1. Entry storage is not cleared.
- in_ready_o = (count <= DEPTH-4). It is based on the registered count only; it does not include a same-cycle dequeue.
- Enqueue fires when in_valid_i && in_ready_o && !flush_i && in_num_i != 0.
  - Lane k (k < in_num_i) is written to entry (tail+k) mod DEPTH.
  - The lane's PC is stored as in_basePC_i + 4*k, using a 32-bit add with wrap.
  - All lanes copy the group's hasException, isRefill and excCode.
  - tail advances by in_num_i.
- in_num_i > 4 is illegal; it is asserted in simulation and the queue writes only 4 lanes.
- in_valid_i while in_ready_o==0 drops the group. Upstream must hold its stage; this is not an error inside the queue.
- Output slots:
  - Slot j shows entry (head+j) mod DEPTH, combinationally from storage.
  - out_valid_o[j] = (count > j).
  - Data on invalid slots is don't-care.
  - A write becomes visible at the outputs the cycle after it is written; there is no fall-through.
- Dequeue:
  - eff_deq = min(deq_num_i, count). Values 3 and deq_num_i > count are clipped.
  - Consuming slot 1 without slot 0 is impossible by construction.
  - head advances by eff_deq.
- Count update: count_next = count + enq_num - eff_deq. Enqueue and dequeue in the same cycle are both applied.
- Flush:
  - When flush_i is high, next state is head=0, tail=0, count=0, and any same-cycle enqueue or dequeue is ignored.
  - Outputs show empty the following cycle.
  - Flush takes priority over everything except reset.
- Reset mid-operation overrides flush and enqueue; the state after reset is identical to the post-reset state above.
- Full boundary: at count = DEPTH-4, a 4-instruction enqueue fills the queue (count=DEPTH) and in_ready_o drops the next cycle. count never exceeds DEPTH.
- Wrap boundary: a group straddling index DEPTH-1 to 0 is stored contiguously modulo DEPTH and read back in order.

Test Plan:
- Reset, then enqueue in_num=4 with basePC=0x1FC0_0000 and insts A,B,C,D -> next cycle out_valid=2'b11, PCs 0x1FC0_0000/0x1FC0_0004, insts A/B, count=4.
- deq_num=2 for 2 cycles after the above -> slots show C,D (PCs ..08/..0C), then out_valid=0, count=0.
- Fill to count=12 (DEPTH=16) then enqueue 4 -> count=16 and in_ready=0. Enqueue attempted while full -> count stays 16 and contents are unchanged.
- Head/tail at 14: enqueue in_num=3 with basePC=0x8000_0010 -> entries 14, 15, 0 hold PCs ..10/..14/..18. Three dequeues read them in order.
- In one cycle, enqueue 3, dequeue 2 and assert flush_i -> next cycle count=0, out_valid=0, in_ready=1. A subsequent enqueue lands at index 0.
- Group with hasException=1, excCode=5'h04, isRefill=1, in_num=2 -> both output slots show hasException=1, excCode=4, isRefill=1.
